pipe_alu_param: RTL and testbench
=================================

PIPE_ALU_PARAM -- requirements
Module: pipe_alu_param

Interface
REQ-001 Parameter W, default 4, meaning operand width in bits; legal range 2..16.
REQ-002 Parameter OW, default 3*W, meaning result width; fixed at 3*W and not overridden independently.
REQ-003 clk1  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block can accept an operand set this cycle.
REQ-007 a, b, c, d  input  W each  unsigned operands.
REQ-008 mode  input  2  operation select, sampled with the operands.
REQ-009 out_valid  output  1  F and neg hold a valid result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 F  output  OW  unsigned result.
REQ-012 neg  output  1  mode-00 difference was negative and was clamped.
REQ-013 busy  output  1  high when any pipeline stage holds valid data.
REQ-014 res_cnt  output  16  count of results delivered.

Function
REQ-015 The pipeline SHALL have three register stages: S1 (operand pre-combine), S2 (combine), S3 (output). Each stage SHALL carry its own valid bit and mode/neg sideband.
REQ-016 S1 SHALL compute operand pair X, Y from mode:
- 00: X=a+b, Y=c-d; when c<d, Y=0 and neg=1.
- 01: X=a+b, Y=c+d.
- 10: X=a*b, Y=c*d.
- 11: X=a*b, Y=c.
REQ-017 S2 SHALL compute P=X+Y for mode 10 and P=X*Y for all other modes. P is zero-extended to OW bits.
REQ-018 Every mode result SHALL fit in OW bits for W>=2, so no truncation or wrap SHALL ever occur.
REQ-019 S3 SHALL drive F and neg directly from registers.
REQ-020 Stall rule: advance = ~out_valid | out_ready. All three stages SHALL shift together only when advance=1, and in_ready SHALL equal advance.
REQ-021 An operand set SHALL be accepted on a rising edge with in_valid & in_ready.
- With no stall, its out_valid SHALL assert after the third rising edge, counting the accepting edge.
- Latency SHALL be 3 cycles; throughput SHALL be one result per cycle.
REQ-022 A cycle with in_valid=0 and advance=1 SHALL insert a bubble: S1 valid is cleared.
REQ-023 While advance=0, all stage contents, F, neg and out_valid SHALL hold unchanged, and input operands SHALL be ignored.
REQ-024 Results SHALL leave in acceptance order, and none SHALL be dropped or duplicated.
REQ-025 res_cnt SHALL increment by 1 on each edge with out_valid & out_ready, and SHALL wrap from 65535 to 0.
REQ-026 busy SHALL be the OR of the S1, S2 and S3 valid bits.
REQ-027 A mode change between consecutive operand sets SHALL take effect per set, with no flush and no bubble.

Reset
REQ-028 Asserting rst SHALL immediately clear all valid bits and set F=0, neg=0, res_cnt=0 and busy=0, without waiting for a clock edge.
REQ-029 While rst is high, in_ready SHALL read 1 and out_valid SHALL read 0.
REQ-030 A reset mid-operation SHALL discard all in-flight sets. No result from before reset SHALL appear after reset.
REQ-031 The first rising edge after rst deasserts SHALL accept operands normally.

Verification (W=4, out_ready=1 unless stated)
REQ-032 mode 00, a=10 b=12 c=6 d=3 -> F=66, neg=0, out_valid 3 edges after acceptance.
REQ-033 Back-to-back sets on consecutive cycles: mode 00 (15,15,15,1), mode 01 (15,15,15,15), mode 10 (15,15,15,15), mode 11 (15,15,15,x) -> F sequence 420, 900, 450, 3375 on consecutive cycles.
REQ-034 mode 00, a=15 b=15 c=3 d=5 -> F=0, neg=1.
REQ-035 Hold out_ready=0 for 4 cycles with 3 sets in flight -> in_ready=0, and F/out_valid held stable. On release, the three results SHALL emerge in order on consecutive cycles, and res_cnt SHALL advance by 3.
REQ-036 Assert rst asynchronously between edges with 2 sets in flight -> out_valid, busy, F and res_cnt go to 0 at once, and no stale result SHALL appear after rst deasserts.
REQ-037 Apply in_valid alternating 1/0 -> out_valid alternates correspondingly 3 cycles later, and busy stays 1 throughout the stream.

Source files
------------

// File: rtl/pipe_alu_param.sv
// Three-stage valid/ready arithmetic pipeline: S1 pre-combines operand pairs,
// S2 combines them, S3 registers the result. All stages stall together.
module pipe_alu_param #(
    parameter int W  = 4,
    parameter int OW = 3 * W
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [W-1:0]  c,
    input  logic [W-1:0]  d,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] F,
    output logic          neg,
    output logic          busy,
    output logic [15:0]   res_cnt
);

    localparam int XW = 2 * W;

    typedef enum logic [1:0] {
        MODE_SUB  = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_MAC  = 2'b10,
        MODE_MUL3 = 2'b11
    } mode_e;

    logic          s1_valid_q, s1_valid_d;
    mode_e         s1_mode_q,  s1_mode_d;
    logic          s1_neg_q,   s1_neg_d;
    logic [XW-1:0] s1_x_q,     s1_x_d;
    logic [XW-1:0] s1_y_q,     s1_y_d;

    logic          s2_valid_q, s2_valid_d;
    logic          s2_neg_q,   s2_neg_d;
    logic [OW-1:0] s2_p_q,     s2_p_d;

    logic          s3_valid_q, s3_valid_d;
    logic          s3_neg_q,   s3_neg_d;
    logic [OW-1:0] s3_f_q,     s3_f_d;

    logic [15:0]   cnt_q,      cnt_d;

    logic          advance;
    mode_e         mode_in;
    logic [XW-1:0] x_pre, y_pre;
    logic          neg_pre;
    logic [OW-1:0] x_ext, y_ext, p_comb;

    assign advance = ~s3_valid_q | out_ready;
    assign mode_in = mode_e'(mode);

    // Operand pre-combine; c-d clamps to zero and flags neg when it would underflow
    always_comb begin
        x_pre   = '0;
        y_pre   = '0;
        neg_pre = 1'b0;
        unique case (mode_in)
            MODE_SUB: begin
                x_pre = XW'(a) + XW'(b);
                if (c < d) begin
                    y_pre   = '0;
                    neg_pre = 1'b1;
                end else begin
                    y_pre = XW'(c) - XW'(d);
                end
            end
            MODE_ADD: begin
                x_pre = XW'(a) + XW'(b);
                y_pre = XW'(c) + XW'(d);
            end
            MODE_MAC: begin
                x_pre = XW'(a) * XW'(b);
                y_pre = XW'(c) * XW'(d);
            end
            MODE_MUL3: begin
                x_pre = XW'(a) * XW'(b);
                y_pre = XW'(c);
            end
            default: ;
        endcase
    end

    // Products and sums are bounded below 2**OW for W>=2, so OW-bit arithmetic never wraps
    always_comb begin
        x_ext  = OW'(s1_x_q);
        y_ext  = OW'(s1_y_q);
        p_comb = (s1_mode_q == MODE_MAC) ? (x_ext + y_ext) : (x_ext * y_ext);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_neg_d   = s1_neg_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s2_valid_d = s2_valid_q;
        s2_neg_d   = s2_neg_q;
        s2_p_d     = s2_p_q;
        s3_valid_d = s3_valid_q;
        s3_neg_d   = s3_neg_q;
        s3_f_d     = s3_f_q;
        cnt_d      = cnt_q;

        if (advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mode_d = mode_in;
                s1_neg_d  = neg_pre;
                s1_x_d    = x_pre;
                s1_y_d    = y_pre;
            end
            s2_valid_d = s1_valid_q;
            s2_neg_d   = s1_neg_q;
            s2_p_d     = p_comb;
            s3_valid_d = s2_valid_q;
            s3_neg_d   = s2_neg_q;
            s3_f_d     = s2_p_q;
        end

        if (s3_valid_q && out_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_SUB;
            s1_neg_q   <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_neg_q   <= 1'b0;
            s2_p_q     <= '0;
            s3_valid_q <= 1'b0;
            s3_neg_q   <= 1'b0;
            s3_f_q     <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_neg_q   <= s1_neg_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s2_valid_q <= s2_valid_d;
            s2_neg_q   <= s2_neg_d;
            s2_p_q     <= s2_p_d;
            s3_valid_q <= s3_valid_d;
            s3_neg_q   <= s3_neg_d;
            s3_f_q     <= s3_f_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = s3_valid_q;
    assign F         = s3_f_q;
    assign neg       = s3_neg_q;
    assign busy      = s1_valid_q | s2_valid_q | s3_valid_q;
    assign res_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_alu_param.sv
// Directed bench for pipe_alu_param (W=4): table-driven streaming vectors plus
// hand-written stall, mid-flight reset and bubble sequences.
module tb_pipe_alu_param;

    localparam int W  = 4;
    localparam int OW = 3 * W;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b, c, d;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] F;
    logic          neg;
    logic          busy;
    logic [15:0]   res_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    pipe_alu_param #(.W(W)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F),
        .neg       (neg),
        .busy      (busy),
        .res_cnt   (res_cnt)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  a, b, c, d;
        int unsigned f;
        logic        neg;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] ia, ib, ic, id);
        in_valid = v;
        mode     = m;
        a        = ia;
        b        = ib;
        c        = ic;
        d        = id;
    endtask

    task automatic edge_sample();
        @(posedge clk1);
        #1;
    endtask

    logic [15:0] cnt0;

    initial begin
        vecs[0]  = '{2'b00, 4'd10, 4'd12, 4'd6,  4'd3,  66,   1'b0};
        vecs[1]  = '{2'b00, 4'd15, 4'd15, 4'd15, 4'd1,  420,  1'b0};
        vecs[2]  = '{2'b01, 4'd15, 4'd15, 4'd15, 4'd15, 900,  1'b0};
        vecs[3]  = '{2'b10, 4'd15, 4'd15, 4'd15, 4'd15, 450,  1'b0};
        vecs[4]  = '{2'b11, 4'd15, 4'd15, 4'd15, 4'd7,  3375, 1'b0};
        vecs[5]  = '{2'b00, 4'd15, 4'd15, 4'd3,  4'd5,  0,    1'b1};
        vecs[6]  = '{2'b01, 4'd0,  4'd0,  4'd0,  4'd0,  0,    1'b0};
        vecs[7]  = '{2'b10, 4'd3,  4'd4,  4'd5,  4'd6,  42,   1'b0};
        vecs[8]  = '{2'b11, 4'd2,  4'd3,  4'd4,  4'd9,  24,   1'b0};
        vecs[9]  = '{2'b00, 4'd5,  4'd5,  4'd7,  4'd7,  0,    1'b0};
        vecs[10] = '{2'b01, 4'd1,  4'd2,  4'd3,  4'd4,  21,   1'b0};

        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_F", F, 0);
        check("rst_cnt", res_cnt, 0);
        edge_sample();
        @(negedge clk1);
        rst = 1'b0;

        // Single set: valid exactly after the third edge, counting the accept edge
        drive(1'b1, vecs[0].mode, vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].d);
        edge_sample();
        @(negedge clk1);
        drive(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
        edge_sample();
        check("lat_e2_out_valid", out_valid, 0);
        edge_sample();
        check("lat_e3_out_valid", out_valid, 1);
        check("lat_e3_F", F, 66);
        edge_sample();
        check("lat_e4_out_valid", out_valid, 0);
        check("lat_cnt", res_cnt, 1);

        // Back-to-back stream through the whole table
        cnt0 = res_cnt;
        for (int i = 0; i < NV + 2; i++) begin
            @(negedge clk1);
            if (i < NV) drive(1'b1, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
            else        drive(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
            edge_sample();
            check("stream_busy", busy, 1);
            if (i >= 2) begin
                check("stream_out_valid", out_valid, 1);
                check("stream_F", F, vecs[i-2].f);
                check("stream_neg", neg, vecs[i-2].neg);
            end
        end
        @(negedge clk1);
        edge_sample();
        check("stream_drained", out_valid, 0);
        check("stream_cnt", res_cnt, 32'(cnt0) + NV);

        // Stall with three sets in flight
        @(negedge clk1);
        drive(1'b1, 2'b01, 4'd1, 4'd2, 4'd3, 4'd4);
        edge_sample();
        @(negedge clk1);
        drive(1'b1, 2'b10, 4'd3, 4'd4, 4'd5, 4'd6);
        edge_sample();
        @(negedge clk1);
        drive(1'b1, 2'b00, 4'd15, 4'd15, 4'd3, 4'd5);
        edge_sample();
        check("stall_first_valid", out_valid, 1);
        cnt0 = res_cnt;
        @(negedge clk1);
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 4'd9, 4'd9, 4'd9, 4'd9);
        #1;
        check("stall_in_ready", in_ready, 0);
        for (int k = 0; k < 4; k++) begin
            edge_sample();
            check("stall_out_valid", out_valid, 1);
            check("stall_F", F, 21);
            check("stall_in_ready_hold", in_ready, 0);
            check("stall_cnt", res_cnt, cnt0);
        end
        @(negedge clk1);
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
        edge_sample();
        check("rel1_valid", out_valid, 1);
        check("rel1_F", F, 42);
        edge_sample();
        check("rel2_valid", out_valid, 1);
        check("rel2_F", F, 0);
        check("rel2_neg", neg, 1);
        edge_sample();
        check("rel3_valid", out_valid, 0);
        check("rel_cnt", res_cnt, 32'(cnt0) + 3);

        // Asynchronous reset with two sets in flight
        @(negedge clk1);
        drive(1'b1, 2'b01, 4'd7, 4'd7, 4'd7, 4'd7);
        edge_sample();
        @(negedge clk1);
        drive(1'b1, 2'b10, 4'd2, 4'd2, 4'd2, 4'd2);
        edge_sample();
        @(negedge clk1);
        drive(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
        check("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_F", F, 0);
        check("arst_cnt", res_cnt, 0);
        check("arst_in_ready", in_ready, 1);
        edge_sample();
        @(negedge clk1);
        rst = 1'b0;
        drive(1'b1, 2'b11, 4'd2, 4'd3, 4'd4, 4'd0);
        edge_sample();
        check("post_rst_e1", out_valid, 0);
        @(negedge clk1);
        drive(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
        edge_sample();
        check("post_rst_e2", out_valid, 0);
        edge_sample();
        check("post_rst_e3_valid", out_valid, 1);
        check("post_rst_e3_F", F, 24);
        for (int k = 0; k < 3; k++) begin
            edge_sample();
            check("post_rst_no_stale", out_valid, 0);
        end
        check("post_rst_cnt", res_cnt, 1);

        // Alternating valid stream: bubbles propagate, busy stays high
        for (int i = 0; i < 10; i++) begin
            @(negedge clk1);
            if (i < 8 && (i % 2 == 0)) drive(1'b1, 2'b01, 4'(i), 4'd1, 4'd2, 4'd3);
            else                       drive(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
            edge_sample();
            if (i < 9) check("alt_busy", busy, 1);
            if (i >= 2) begin
                check("alt_out_valid", out_valid, ((i - 2) % 2 == 0) ? 1 : 0);
                if ((i - 2) % 2 == 0) check("alt_F", F, (i - 2 + 1) * 5);
            end
        end
        check("alt_cnt", res_cnt, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
